load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/lsu_pkg.sv | 34 +++
 rtl/lsu_lane_align.sv | 49 ++++
 rtl/load_store_unit.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: access size encodings, the
// control state enum and the alignment rule used at request acceptance.
package lsu_pkg;

    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } lsu_size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        RMW_READ = 3'd2,
        WRITE    = 3'd3,
        RESP     = 3'd4
    } lsu_state_e;

    // An access is rejected when it is not naturally aligned or its size is illegal.
    function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = addr_lo[0];
            SZ_WORD: bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for the load/store unit (purely combinational).
// Ports:
//   addr_lo      - low two address bits selecting the lane(s)
//   size         - access size
//   is_unsigned  - zero-extend (1) or sign-extend (0) sub-word loads
//   rdata        - word read from memory
//   wdata        - right-justified store data
//   load_data_c  - extracted and extended load result
//   merge_data_c - rdata with the target lanes replaced by wdata
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  lsu_size_e         size,
    input  logic              is_unsigned,
    input  logic [DATA_W-1:0] rdata,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] load_data_c,
    output logic [DATA_W-1:0] merge_data_c
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Little-endian lane extraction and extension.
    always_comb begin
        byte_sel    = rdata[{addr_lo, 3'b000} +: 8];
        half_sel    = addr_lo[1] ? rdata[31:16] : rdata[15:0];
        load_data_c = rdata;
        case (size)
            SZ_BYTE: load_data_c = is_unsigned ? {24'b0, byte_sel}
                                               : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_data_c = is_unsigned ? {16'b0, half_sel}
                                               : {{16{half_sel[15]}}, half_sel};
            default: load_data_c = rdata;
        endcase
    end

    // Store merge: replace only the addressed lanes of the read word.
    always_comb begin
        merge_data_c = rdata;
        case (size)
            SZ_BYTE: merge_data_c[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: merge_data_c[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
            default: merge_data_c = wdata;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the pipeline and a combinational-read data memory.
// Sub-word stores are performed as read-modify-write.
// Ports:
//   clk, reset              - clock, asynchronous active-high reset
//   req_*                   - access request (valid/ready handshake)
//   resp_valid/rdata/misaligned - one-cycle completion pulse and result
//   mem_write/address/write_data - data memory write port and address
//   mem_read_data           - combinational memory read of mem_address
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_misaligned,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    lsu_state_e        state_q, state_d;
    logic              store_q, store_d;
    lsu_size_e         size_q, size_d;
    logic              uns_q, uns_d;
    logic              mis_q, mis_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_mis_q, resp_mis_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] load_data_c;
    logic [DATA_W-1:0] merge_data_c;

    lsu_lane_align u_lane_align (
        .addr_lo      (addr_q[1:0]),
        .size         (size_q),
        .is_unsigned  (uns_q),
        .rdata        (mem_read_data),
        .wdata        (wdata_q),
        .load_data_c  (load_data_c),
        .merge_data_c (merge_data_c)
    );

    // Next state, request latching and next values of the registered outputs.
    always_comb begin
        state_d = state_q;
        store_d = store_q;
        size_d  = size_q;
        uns_d   = uns_q;
        mis_d   = mis_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    store_d = req_store;
                    size_d  = lsu_size_e'(req_size);
                    uns_d   = req_unsigned;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    mis_d   = is_misaligned(lsu_size_e'(req_size), req_addr[1:0]);
                    if (mis_d)                             state_d = RESP;
                    else if (!req_store)                   state_d = LOAD;
                    else if (lsu_size_e'(req_size) == SZ_WORD) state_d = WRITE;
                    else                                   state_d = RMW_READ;
                end
            end
            LOAD:     state_d = RESP;
            RMW_READ: state_d = WRITE;
            WRITE:    state_d = RESP;
            RESP:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        req_ready_d   = (state_d == IDLE);
        resp_valid_d  = (state_d == RESP);
        resp_mis_d    = (state_d == RESP) && mis_d;
        // Only a LOAD cycle feeds data into the response; stores and errors return 0.
        resp_rdata_d  = (state_q == LOAD) ? load_data_c : DATA_W'(0);
        mem_write_d   = (state_d == WRITE);
        mem_address_d = (state_d != IDLE) ? {addr_d[ADDR_W-1:2], 2'b00} : ADDR_W'(0);

        // Word stores write req_wdata straight from IDLE; RMW writes the merged word.
        if (state_d == WRITE)
            mem_wdata_d = (state_q == RMW_READ) ? merge_data_c : wdata_d;
        else if (state_d != IDLE)
            mem_wdata_d = wdata_d;
        else
            mem_wdata_d = DATA_W'(0);
    end

    // State, latched request and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            store_q       <= 1'b0;
            size_q        <= SZ_BYTE;
            uns_q         <= 1'b0;
            mis_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            req_ready_q   <= 1'b1;
            resp_valid_q  <= 1'b0;
            resp_mis_q    <= 1'b0;
            resp_rdata_q  <= '0;
            mem_write_q   <= 1'b0;
            mem_address_q <= '0;
            mem_wdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            store_q       <= store_d;
            size_q        <= size_d;
            uns_q         <= uns_d;
            mis_q         <= mis_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            req_ready_q   <= req_ready_d;
            resp_valid_q  <= resp_valid_d;
            resp_mis_q    <= resp_mis_d;
            resp_rdata_q  <= resp_rdata_d;
            mem_write_q   <= mem_write_d;
            mem_address_q <= mem_address_d;
            mem_wdata_q   <= mem_wdata_d;
        end
    end

    assign req_ready       = req_ready_q;
    assign resp_valid      = resp_valid_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_rdata      = resp_rdata_q;
    assign mem_write       = mem_write_q;
    assign mem_address     = mem_address_q;
    assign mem_write_data  = mem_wdata_q;

endmodule
